// File: rtl/stv_upsizer_pkg.sv
// Shared defaults for the stream upsizer.
package stv_upsizer_pkg;

  localparam int STV_IN_W_DEF  = 8;
  localparam int STV_RATIO_DEF = 4;

endpackage

// File: rtl/stv_upsizer.sv
// Serial-to-parallel packer: RATIO narrow beats -> one wide word, lane 0 in LSBs.
// din_last closes a partial word early. The output is registered and din_ready
// is decoded from the state register only, so no path crosses the block
// combinationally. When the output slot is busy, the completed word is parked
// in acc (HOLD) and intake stops until the output is taken.
module stv_upsizer
  import stv_upsizer_pkg::*;
#(
  parameter int IN_W  = STV_IN_W_DEF,
  parameter int RATIO = STV_RATIO_DEF,
  parameter int CNT_W = $clog2(RATIO)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  clear,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [IN_W-1:0]       din,
  input  logic                  din_last,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [IN_W*RATIO-1:0] dout,
  output logic [RATIO-1:0]      dout_keep,
  output logic                  dout_last
);

  localparam int OUT_W = IN_W * RATIO;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] acc;
  logic [RATIO-1:0] hold_keep;
  logic             hold_last;

  logic [OUT_W-1:0] merged;
  logic [RATIO-1:0] merged_keep;

  logic accept, completing, slot_free;
  logic ld_direct, ld_hold, ld_release;

  assign din_ready  = (state == ST_FILL);
  assign accept     = din_valid && din_ready;
  assign completing = (cnt == CNT_MAX) || din_last;
  assign slot_free  = !dout_valid || dout_ready;
  assign ld_direct  = accept && completing && slot_free;
  assign ld_hold    = accept && completing && !slot_free;
  assign ld_release = (state == ST_HOLD) && dout_ready;

  // Merge lanes below cnt from acc with the current beat at lane cnt; stale
  // lanes above cnt are forced to zero.
  always_comb begin
    merged      = '0;
    merged_keep = '0;
    for (int j = 0; j < RATIO; j++) begin
      if (CNT_W'(j) < cnt) begin
        merged[j*IN_W +: IN_W] = acc[j*IN_W +: IN_W];
        merged_keep[j]         = 1'b1;
      end else if (CNT_W'(j) == cnt) begin
        merged[j*IN_W +: IN_W] = din;
        merged_keep[j]         = 1'b1;
      end
    end
  end

  // Control state: lane counter, FILL/HOLD, output valid/keep/last.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= ST_FILL;
      cnt        <= '0;
      dout_valid <= 1'b0;
      dout_keep  <= '0;
      dout_last  <= 1'b0;
    end else if (clear) begin
      state      <= ST_FILL;
      cnt        <= '0;
      dout_valid <= 1'b0;
      dout_keep  <= '0;
      dout_last  <= 1'b0;
    end else begin
      if (accept)
        cnt <= completing ? '0 : cnt + CNT_W'(1);

      if (ld_hold)
        state <= ST_HOLD;
      else if (ld_release)
        state <= ST_FILL;

      if (ld_direct) begin
        dout_valid <= 1'b1;
        dout_keep  <= merged_keep;
        dout_last  <= din_last;
      end else if (ld_release) begin
        dout_valid <= 1'b1;
        dout_keep  <= hold_keep;
        dout_last  <= hold_last;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

  // Data path: lane accumulation, parking a word in HOLD, output data load.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (ld_hold) begin
        acc       <= merged;
        hold_keep <= merged_keep;
        hold_last <= din_last;
      end else if (accept && !completing) begin
        for (int j = 0; j < RATIO; j++)
          if (CNT_W'(j) == cnt) acc[j*IN_W +: IN_W] <= din;
      end

      if (ld_direct)
        dout <= merged;
      else if (ld_release)
        dout <= acc;
    end
  end

`ifdef ASSERT_ON
  // Upstream must keep an unaccepted beat stable.
  a_din_stable: assert property (@(posedge clk) disable iff (arst)
    (din_valid && !din_ready && !clear) |=> (din_valid && $stable(din)));

  // Valid words have a nonempty keep mask contiguous from lane 0.
  a_keep_contig: assert property (@(posedge clk) disable iff (arst)
    dout_valid |-> (dout_keep[0] && ((dout_keep & (dout_keep + RATIO'(1))) == '0)));
`endif

endmodule

// File: tb/tb_stv_upsizer.sv
// Bench for stv_upsizer: vector table, hand-written corner sequences and a
// randomized run, all scored against a queue-based word model.
module tb_stv_upsizer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;

  logic             clk = 1'b0;
  logic             arst, clear;
  logic             din_valid, din_ready, din_last;
  logic [IN_W-1:0]  din;
  logic             dout_valid, dout_ready, dout_last;
  logic [OUT_W-1:0] dout;
  logic [RATIO-1:0] dout_keep;

  int total = 0;
  int bad   = 0;
  int takes = 0;

  always #5 clk = ~clk;

  stv_upsizer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk(clk), .arst(arst), .clear(clear),
    .din_valid(din_valid), .din_ready(din_ready), .din(din), .din_last(din_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .dout_keep(dout_keep), .dout_last(dout_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: collect accepted beats; a word is complete at RATIO
  // beats or on din_last, zero-filled above the last beat. Words leave in order.
  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [RATIO-1:0] k;
    logic             l;
  } word_t;

  logic [IN_W-1:0] part[$];
  word_t           expq[$];
  word_t           w, pv;
  logic            pv_stall = 1'b0;

  // Scoreboard, sampled mid-cycle where all handshake inputs are settled.
  always @(negedge clk) begin
    if (arst || clear) begin
      part.delete();
      expq.delete();
      pv_stall = 1'b0;
    end else begin
      if (pv_stall)
        chk("hold_stable", {dout_valid, dout_last, dout_keep, dout}, {1'b1, pv.l, pv.k, pv.d});
      if (dout_valid && dout_ready) begin
        takes++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h want none", dout);
        end else begin
          w = expq.pop_front();
          chk("word", {dout_last, dout_keep, dout}, {w.l, w.k, w.d});
        end
      end
      if (din_valid && din_ready) begin
        part.push_back(din);
        if (part.size() == RATIO || din_last) begin
          w.d = '0;
          for (int i = 0; i < part.size(); i++)
            w.d = w.d | (OUT_W'(part[i]) << (i * IN_W));
          w.k = RATIO'((1 << part.size()) - 1);
          w.l = din_last;
          expq.push_back(w);
          part.delete();
        end
      end
      pv_stall = dout_valid && !dout_ready;
      pv.d = dout;
      pv.k = dout_keep;
      pv.l = dout_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [IN_W-1:0] d, input logic l);
    din_valid = 1'b1;
    din       = d;
    din_last  = l;
    tick();
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  typedef struct {
    int               n;
    logic [OUT_W-1:0] data;
    logic             last;
    logic [OUT_W-1:0] ed;
    logic [RATIO-1:0] ek;
    logic             el;
  } vec_t;

  vec_t vt[5];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic a;
    int   t0;

    arst = 1'b1; clear = 1'b0; din_valid = 1'b0; din = '0; din_last = 1'b0; dout_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", dout_valid, 0);
    chk("rst_keep",  dout_keep,  0);
    chk("rst_last",  dout_last,  0);
    chk("rst_ready", din_ready,  1);
    arst = 1'b0;
    tick();

    // n, beats (lane 0 in LSBs), last on final beat, expected word/keep/last
    vt[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF, 1'b0};
    vt[1] = '{2, 32'h0000A2A1, 1'b1, 32'h0000A2A1, 4'h3, 1'b1};
    vt[2] = '{4, 32'hDDCCBBAA, 1'b1, 32'hDDCCBBAA, 4'hF, 1'b1};
    vt[3] = '{3, 32'h00332211, 1'b1, 32'h00332211, 4'h7, 1'b1};
    vt[4] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'h1, 1'b1};
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < vt[v].n; b++) begin
        chk("vec_ready", din_ready, 1);
        beat(vt[v].data[b*IN_W +: IN_W], vt[v].last && (b == vt[v].n - 1));
      end
      chk("vec_valid", dout_valid, 1);
      chk("vec_dout",  dout,       vt[v].ed);
      chk("vec_keep",  dout_keep,  vt[v].ek);
      chk("vec_last",  dout_last,  vt[v].el);
    end
    tick();

    // Output stalled: second word parks in HOLD and intake stops.
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(8'h10 + 8'(i), 1'b0);
      if (i == 3) chk("stall_first", {dout_valid, dout}, {1'b1, 32'h13121110});
    end
    chk("hold_ready", din_ready, 0);
    tick(); tick();
    chk("hold_dout", {dout_valid, dout_keep, dout}, {1'b1, 4'hF, 32'h13121110});
    dout_ready = 1'b1;
    tick();
    chk("release_dout",  {dout_valid, dout}, {1'b1, 32'h17161514});
    chk("release_ready", din_ready, 1);
    tick();
    chk("release_empty", dout_valid, 0);

    // Back-to-back stream: no backpressure, four words.
    t0 = takes;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_ready", din_ready, 1);
      beat(8'h40 + 8'(i), 1'b0);
    end
    tick();
    chk("b2b_words", takes - t0, 4);

    // Clear drops a partial word.
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_valid", dout_valid, 0);
    for (int i = 1; i <= 4; i++) beat(8'(i), 1'b0);
    chk("clear_word", {dout_valid, dout_keep, dout}, {1'b1, 4'hF, 32'h04030201});
    tick();

    // Async reset while holding.
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(8'h20 + 8'(i), 1'b0);
    chk("pre_arst_ready", din_ready, 0);
    arst = 1'b1;
    #1;
    chk("arst_valid", dout_valid, 0);
    chk("arst_ready", din_ready,  1);
    chk("arst_keep",  dout_keep,  0);
    tick();
    arst = 1'b0;
    dout_ready = 1'b1;
    for (int i = 1; i <= 4; i++) beat(8'h30 + 8'(i), 1'b0);
    chk("post_arst_word", {dout_valid, dout_keep, dout_last, dout}, {1'b1, 4'hF, 1'b0, 32'h34333231});
    tick();

    // Randomized traffic with backpressure and occasional clear.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      a = din_valid && din_ready && !clear;
      @(posedge clk);
      #1;
      clear = ($urandom_range(0, 99) == 0);
      if (!din_valid || a) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din       = 8'($urandom);
        din_last  = ($urandom_range(0, 4) == 0);
      end
      dout_ready = ($urandom_range(0, 2) != 0);
    end
    clear = 1'b0;
    dout_ready = 1'b1;
    for (int k = 0; k < 20 && din_valid; k++) begin
      @(negedge clk);
      a = din_valid && din_ready;
      @(posedge clk);
      #1;
      if (a) begin
        din_valid = 1'b0;
        din_last  = 1'b0;
      end
    end
    for (int k = 0; k < 10 && expq.size() != 0; k++) tick();
    chk("drain", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stv_upsizer.md
Name: stv_upsizer

Overview:
Ready/valid width upsizer (serial-to-parallel packer). It accumulates RATIO narrow input beats into one wide output word, lane 0 in the LSBs. A din_last beat flushes a partial word early. It sits directly upstream of the team's stream buffer stage and feeds it wide words. Its output is registered, and din_ready comes from a register only, so neither forward nor backward paths are combinational through the block.

Parameters:
IN_W, 8, width of one input beat in bits (>=1)
RATIO, 4, input beats per output word (>=2; not required to be a power of two)
CNT_W, $clog2(RATIO), derived lane-counter width; must not be overridden

Ports:
clk  input  1  clock, all logic on rising edge
arst  input  1  asynchronous reset, active-high
clear  input  1  synchronous clear; drops any partial or pending word
din_valid  input  1  input beat valid
din_ready  output  1  input beat ready
din  input  IN_W  input beat data
din_last  input  1  final beat of a packet; completes the current word
dout_valid  output  1  output word valid
dout_ready  input  1  output word ready
dout  output  IN_W*RATIO  packed word; lane i = dout[i*IN_W +: IN_W]
dout_keep  output  RATIO  lane-valid mask, contiguous from lane 0
dout_last  output  1  word ends a packet

Behaviour:
- Reset (arst high, asynchronous): state=FILL, cnt=0, dout_valid=0, dout_keep=0, dout_last=0, din_ready=1. Data registers (acc, dout) are not reset.
- Clear (sync, highest priority after arst): same as reset for state, cnt, dout_valid, dout_keep and dout_last. Partial acc and any held output word are discarded. No handshake is honoured in that cycle.
- Beat accepted = din_valid && din_ready. din_ready = (state==FILL). It must not depend combinationally on din_valid, din_last or dout_ready.
- Accepted beat writes lane cnt of acc and sets keep bit cnt.
- A beat is "completing" if cnt==RATIO-1 or din_last=1.
- Non-completing beat: cnt <= cnt+1.
- Out slot free = !dout_valid || dout_ready.
- State FILL, completing beat, out slot free:
  - The word goes straight to the output registers next edge: dout = acc merged with the current beat.
  - Unfilled lanes of dout are forced to 0.
  - dout_keep = filled lanes; dout_last = din_last; dout_valid=1.
  - cnt <= 0; state stays FILL.
- State FILL, completing beat, out slot busy: merged word, keep and last latch into acc; cnt <= 0; state -> HOLD.
- State HOLD: din_ready=0. When dout_ready=1, the output handshake completes, acc moves to the output registers (dout_valid stays 1), and state -> FILL.
- Output handshake with no new word loading: dout_valid <= 0.
- While dout_valid && !dout_ready, dout, dout_keep and dout_last hold stable.
- Latency: a word is visible on dout the cycle after its completing beat is accepted.
- Throughput: one beat per cycle sustained while dout_ready=1. At most one bubble per stall release from HOLD.
- Simultaneous events:
  - Completing beat while the current output is being taken: the new word replaces it, with no gap.
  - din_last on the beat with cnt==RATIO-1: full keep, dout_last=1.
- Zero-length words cannot occur; every word has keep[0]=1.
- Arithmetic: cnt wraps only by explicit reset to 0, never by overflow.
- Assertions (under the codebase assert define, disabled in reset):
  - din_valid and din held stable while stalled.
  - dout_keep is contiguous from lane 0.

Decomposition:
- Package: no new package types required. The state enum (FILL, HOLD) stays local to the module.
- No sub-module: the output register is integral to the HOLD logic. Additional timing isolation downstream is provided by instantiating the existing stream buffer after this block, not inside it.

Test Plan:
1. IN_W=8, RATIO=4, dout_ready=1, beats 11,22,33,44 on consecutive cycles -> next cycle dout=0x44332211, keep=4'hF, last=0, din_ready stays 1.
2. Beats A1,A2 with din_last on A2 -> dout=0x0000A2A1, keep=4'h3, last=1; the next word starts at lane 0.
3. dout_ready=0, send 8 beats -> first word held stable; after 8th beat state HOLD, din_ready=0. Raise dout_ready -> first word consumed, second presented next cycle, din_ready=1 again.
4. 16 beats back-to-back with dout_ready=1 -> 4 words, din_ready never deasserts, words contiguous.
5. After 2 beats, pulse clear -> no output word. The next 4 beats 01..04 give dout=0x04030201, keep=4'hF.
6. Assert arst while in HOLD with dout_valid=1 -> dout_valid=0, din_ready=1 immediately (asynchronous). After release, normal packing resumes from lane 0.
